axi_dma_burst_splitter: RTL
===========================

// Module: axi_dma_burst_splitter
// PURPOSE
//  Splits one DMA transfer command (start address, byte length, beat size, burst type) into a
//  sequence of legal AXI4 burst descriptors. Bursts are bounded by MAX_BURST_LEN, the 4KB
//  (BOUNDARY) rule, unaligned start and narrow beat sizes. One instance feeds the AR side and
//  one feeds the AW side of each axi_dma_controller channel; the W-strobe logic uses burst_bytes.
// PARAMETERS
//  ADDR_WD        32    address width (bits)
//  DATA_WD        32    AXI data width (bits); max beat size = log2(DATA_WD/8)
//  LEN_WD         32    width of cmd_len (bytes)
//  MAX_BURST_LEN  16    max beats per INCR burst (1..256); FIXED bursts are also capped at 16
//  BOUNDARY       4096  address boundary an INCR burst must not cross (power of 2)
// PORTS
//  clk            in   1        clock
//  rst_n          in   1        asynchronous reset, active low
//  cmd_valid      in   1        command valid
//  cmd_ready      out  1        command accepted when valid&ready
//  cmd_addr       in   ADDR_WD  start byte address (any alignment)
//  cmd_len        in   LEN_WD   transfer length in bytes
//  cmd_size       in   3        AXI beat size code
//  cmd_burst      in   2        AXI burst type (FIXED=0, INCR=1; WRAP=2 is rejected)
//  burst_valid    out  1        descriptor valid
//  burst_ready    in   1        descriptor consumed when valid&ready
//  burst_addr     out  ADDR_WD  AxADDR; may be unaligned on the first burst only
//  burst_len      out  8        AxLEN (beats-1)
//  burst_size     out  3        AxSIZE (= latched cmd_size)
//  burst_burst    out  2        AxBURST (= latched cmd_burst)
//  burst_bytes    out  LEN_WD   payload bytes carried by this burst
//  burst_last     out  1        last burst of the current command
//  done           out  1        1-cycle pulse: command fully issued (or empty/rejected)
//  err            out  1        1-cycle pulse with done: command rejected
// BEHAVIOUR
//  Reset: state=IDLE; cmd_ready=1; burst_valid, done and err=0; all other outputs=0.
//  FSM states: IDLE -> CALC -> EMIT -> (CALC | IDLE).
//  IDLE: cmd_ready=1. On handshake, latch addr, rem=cmd_len, size and burst.
//    If cmd_len==0, pulse done next cycle and stay in IDLE.
//    If cmd_size>log2(DATA_WD/8) or cmd_burst==WRAP/3, pulse done+err next cycle and stay in IDLE.
//    Otherwise go to CALC.
//  CALC (1 cycle, cmd_ready=0): B=1<<size; off=addr&(B-1); al=addr-off.
//    n_need=ceil((off+rem)/B).
//    INCR: n_bnd=(BOUNDARY-(al&(BOUNDARY-1)))/B; n=min(n_need,MAX_BURST_LEN,n_bnd).
//    FIXED: n=min(n_need,16) with the same byte accounting; the address never advances.
//    Register burst_addr=addr, burst_len=n-1, burst_bytes=min(n*B-off,rem),
//    burst_last=(rem==burst_bytes). Go to EMIT.
//  EMIT: burst_valid=1. All burst_* outputs stay stable until burst_ready.
//    On handshake: rem-=burst_bytes; INCR addr=al+n*B.
//    If burst_last, pulse done, go to IDLE with burst_valid=0; otherwise go to CALC.
//  Throughput: one descriptor per 2 cycles. One idle cycle between done and the next cmd_ready.
//  Arithmetic: intermediates are LEN_WD+1 bits wide. An address that wraps past 2^ADDR_WD
//    rolls over modulo and is not flagged.
//  cmd_valid while busy is ignored (ready=0); the source must hold its command.
//  Async reset mid-command drops it: no done, burst_valid=0 immediately.
// TESTING (DATA_WD=32, MAX_BURST_LEN=16, size=2, INCR unless noted)
//  addr 0x0, len 64 -> one burst {0x0, len 15, bytes 64, last=1}, then done.
//  addr 0x0, len 100 -> {0x0, 15, 64, last=0}, {0x40, 8, 36, last=1}.
//  addr 0xFF8, len 32 -> {0xFF8, 1, 8}, {0x1000, 5, 24, last=1}; no burst crosses 4KB.
//  addr 0x3, len 10 -> {0x3, 3, 10, last=1}.
//  addr 0x1, len 6, size 0, FIXED -> {0x1, 5, 6}.
//  len 0 -> done with no burst. size 3 -> done+err with no burst.
//  burst_ready low for 5 cycles -> burst outputs stable throughout.
//  rst_n asserted during EMIT -> burst_valid=0 and cmd_ready=1 after release.

Source files
------------

// File: rtl/axi_dma_burst_splitter.sv
`default_nettype none
// ============================================================================
// Module   : axi_dma_burst_splitter
// Purpose  : Breaks one DMA transfer command (start address, byte length,
//            beat size, burst type) into a sequence of legal AXI4 burst
//            descriptors. Each burst is limited by MAX_BURST_LEN, by the
//            BOUNDARY crossing rule (INCR only), by an unaligned start and
//            by narrow beat sizes.
// Ports    : clk, rst_n                 - clock, async active-low reset
//            cmd_valid/ready/addr/len/size/burst - transfer command in
//            burst_valid/ready/addr/len/size/burst/bytes/last - descriptor out
//            done, err                  - end-of-command pulses
// Revision : 1.0 - initial release
// ============================================================================
module axi_dma_burst_splitter #(
    parameter int ADDR_WD       = 32,
    parameter int DATA_WD       = 32,
    parameter int LEN_WD        = 32,
    parameter int MAX_BURST_LEN = 16,
    parameter int BOUNDARY      = 4096
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [ADDR_WD-1:0] cmd_addr,
    input  logic [LEN_WD-1:0]  cmd_len,
    input  logic [2:0]         cmd_size,
    input  logic [1:0]         cmd_burst,
    output logic               burst_valid,
    input  logic               burst_ready,
    output logic [ADDR_WD-1:0] burst_addr,
    output logic [7:0]         burst_len,
    output logic [2:0]         burst_size,
    output logic [1:0]         burst_burst,
    output logic [LEN_WD-1:0]  burst_bytes,
    output logic               burst_last,
    output logic               done,
    output logic               err
);

    localparam int       c_XW        = LEN_WD + 1;
    localparam int       c_MAX_SIZE  = $clog2(DATA_WD / 8);
    localparam int       c_FIXED_CAP = 16;
    localparam logic [1:0] c_INCR    = 2'd1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_EMIT = 2'd2
    } state_t;

    state_t r_state, w_state_nxt;

    logic [ADDR_WD-1:0] r_addr, r_adv, r_baddr;
    logic [LEN_WD-1:0]  r_rem, r_bbytes;
    logic [2:0]         r_size;
    logic [1:0]         r_burst;
    logic [7:0]         r_blen;
    logic               r_blast, r_done, r_err;

    logic               w_cmd_hs, w_bad;
    logic [c_XW-1:0]    w_beat, w_off, w_sum, w_need, w_bnd, w_n, w_span, w_bytes;
    logic [ADDR_WD-1:0] w_al;

    assign w_cmd_hs = cmd_valid && cmd_ready;
    // WRAP (2) and reserved (3) both have bit 1 set.
    assign w_bad    = (cmd_size > 3'(c_MAX_SIZE)) || cmd_burst[1];

    // Burst sizing for the current residual (r_addr, r_rem).
    always_comb begin
        w_beat = c_XW'(1) << r_size;
        w_off  = c_XW'(r_addr & ADDR_WD'(w_beat - c_XW'(1)));
        w_al   = r_addr - ADDR_WD'(w_off);
        w_sum  = w_off + c_XW'(r_rem);
        // ceil without an add that could overflow the intermediate width
        w_need = (w_sum >> r_size) + c_XW'(|(w_sum & (w_beat - c_XW'(1))));
        w_bnd  = (c_XW'(BOUNDARY) - c_XW'(w_al & ADDR_WD'(BOUNDARY - 1))) >> r_size;
        if (r_burst == c_INCR) begin
            w_n = (w_need < c_XW'(MAX_BURST_LEN)) ? w_need : c_XW'(MAX_BURST_LEN);
            if (w_bnd < w_n) begin
                w_n = w_bnd;
            end
        end else begin
            w_n = (w_need < c_XW'(c_FIXED_CAP)) ? w_need : c_XW'(c_FIXED_CAP);
        end
        w_span  = w_n << r_size;
        w_bytes = ((w_span - w_off) < c_XW'(r_rem)) ? (w_span - w_off) : c_XW'(r_rem);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        // No new command during the done cycle: leaves one idle cycle.
        cmd_ready   = 1'b0;
        burst_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                cmd_ready = !r_done;
                if (w_cmd_hs && (cmd_len != '0) && !w_bad) begin
                    w_state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                w_state_nxt = S_EMIT;
            end
            S_EMIT: begin
                burst_valid = 1'b1;
                if (burst_ready) begin
                    w_state_nxt = r_blast ? S_IDLE : S_CALC;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr   <= '0;
            r_adv    <= '0;
            r_baddr  <= '0;
            r_rem    <= '0;
            r_bbytes <= '0;
            r_size   <= '0;
            r_burst  <= '0;
            r_blen   <= '0;
            r_blast  <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_cmd_hs) begin
                        r_addr  <= cmd_addr;
                        r_rem   <= cmd_len;
                        r_size  <= cmd_size;
                        r_burst <= cmd_burst;
                        if (cmd_len == '0) begin
                            r_done <= 1'b1;
                        end else if (w_bad) begin
                            r_done <= 1'b1;
                            r_err  <= 1'b1;
                        end
                    end
                end
                S_CALC: begin
                    r_baddr  <= r_addr;
                    r_blen   <= 8'(w_n - c_XW'(1));
                    r_bbytes <= LEN_WD'(w_bytes);
                    r_blast  <= (c_XW'(r_rem) == w_bytes);
                    r_adv    <= w_al + ADDR_WD'(w_span);
                end
                S_EMIT: begin
                    if (burst_ready) begin
                        r_rem <= r_rem - r_bbytes;
                        // FIXED bursts keep hitting the same address.
                        if (r_burst == c_INCR) begin
                            r_addr <= r_adv;
                        end
                        if (r_blast) begin
                            r_done <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign burst_addr  = r_baddr;
    assign burst_len   = r_blen;
    assign burst_size  = r_size;
    assign burst_burst = r_burst;
    assign burst_bytes = r_bbytes;
    assign burst_last  = r_blast;
    assign done        = r_done;
    assign err         = r_err;

endmodule
`default_nettype wire
